// File: rtl/interrupt_scheduler_if.sv
// Interrupt scheduler bus: requester event/ack lines plus the endpoint
// cfg_interrupt MSI handshake.
//   master: scheduler side (drives src_ack, cfg_interrupt_n, cfg_interrupt_di)
//   slave : requester/endpoint side (drives src_req, cfg_interrupt_rdy_n)
interface interrupt_scheduler_if #(
  parameter int unsigned NUM_SRC = 2
);
  logic [NUM_SRC-1:0] src_req;
  logic [NUM_SRC-1:0] src_ack;
  logic               cfg_interrupt_n;
  logic               cfg_interrupt_rdy_n;
  logic [7:0]         cfg_interrupt_di;

  modport master (
    input  src_req,
    input  cfg_interrupt_rdy_n,
    output src_ack,
    output cfg_interrupt_n,
    output cfg_interrupt_di
  );

  modport slave (
    output src_req,
    output cfg_interrupt_rdy_n,
    input  src_ack,
    input  cfg_interrupt_n,
    input  cfg_interrupt_di
  );
endinterface

// File: rtl/interrupt_scheduler.sv
// MSI interrupt scheduler shared by NUM_SRC requesters.
// Requester pulses are latched as pending flags, arbitrated round-robin and
// issued over the cfg_interrupt handshake, with at least interrupt_period
// cycles of hold-off between deliveries.
// Ports:
//   trn_clk            clock, rising edge
//   reset              synchronous active-high reset
//   interrupts_enabled 1 = new requests may be issued
//   interrupt_period   minimum spacing between deliveries (sampled at handshake)
//   bus                src_req/src_ack and cfg_interrupt_n/_rdy_n/_di
//   irq_count          delivered-interrupt counter (wraps)
module interrupt_scheduler #(
  parameter int unsigned NUM_SRC  = 2,
  parameter logic [7:0]  VEC_BASE = 8'h00
) (
  input  logic                 trn_clk,
  input  logic                 reset,
  input  logic                 interrupts_enabled,
  input  logic [31:0]          interrupt_period,
  interrupt_scheduler_if.master bus,
  output logic [31:0]          irq_count
);

  localparam int unsigned GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [NUM_SRC-1:0] clr;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [31:0]        hold_q, hold_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               cfg_n_q, cfg_n_d;
  logic [7:0]         di_q, di_d;

  // Round-robin pick: lowest pending index above last grant, else lowest
  // pending index overall (wrap-around).
  logic          hi_vld, lo_vld, sel_vld;
  logic [GW-1:0] hi_sel, lo_sel, sel;

  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_sel = '0;
    lo_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pending_q[i]) begin
        if (i > 32'(last_q)) begin
          if (!hi_vld) begin
            hi_vld = 1'b1;
            hi_sel = GW'(i);
          end
        end else if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_sel = GW'(i);
        end
      end
    end
    sel     = hi_vld ? hi_sel : lo_sel;
    sel_vld = hi_vld | lo_vld;
  end

  always_comb begin
    state_d = state_q;
    cfg_n_d = cfg_n_q;
    di_d    = di_q;
    ack_d   = '0;
    clr     = '0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (interrupts_enabled && sel_vld) begin
          cfg_n_d = 1'b0;
          di_d    = VEC_BASE + 8'(sel);
          grant_d = sel;
          state_d = REQ;
        end
      end
      REQ: begin
        // Once raised, the request is held until the core accepts it,
        // regardless of interrupts_enabled.
        if (!bus.cfg_interrupt_rdy_n) begin
          cfg_n_d        = 1'b1;
          clr[grant_q]   = 1'b1;
          ack_d[grant_q] = 1'b1;
          cnt_d          = cnt_q + 32'd1;
          last_d         = grant_q;
          hold_d         = (interrupt_period == 32'd0) ? 32'd1 : interrupt_period;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        hold_d = hold_q - 32'd1;
        if (hold_q <= 32'd1) begin
          hold_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new event in the clearing cycle keeps the flag set.
    pending_d = (pending_q & ~clr) | bus.src_req;
  end

  always_ff @(posedge trn_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      pending_q <= '0;
      ack_q     <= '0;
      last_q    <= GW'(NUM_SRC - 1);
      grant_q   <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      cfg_n_q   <= 1'b1;
      di_q      <= '0;
    end else begin
      pending_q <= pending_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      cfg_n_q   <= cfg_n_d;
      di_q      <= di_d;
    end
  end

  assign bus.src_ack          = ack_q;
  assign bus.cfg_interrupt_n  = cfg_n_q;
  assign bus.cfg_interrupt_di = di_q;
  assign irq_count            = cnt_q;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Self-checking bench for interrupt_scheduler: table of single-burst
// vectors plus hand-written multi-cycle sequences; expected deliveries are
// queued when requests are driven and popped when src_ack fires.
module tb_interrupt_scheduler;

  localparam int unsigned NS = 2;
  localparam logic [7:0]  VB = 8'h40;

  logic        trn_clk = 1'b0;
  logic        reset = 1'b1;
  logic        interrupts_enabled = 1'b1;
  logic [31:0] interrupt_period = 32'd10;
  logic [31:0] irq_count;

  interrupt_scheduler_if #(.NUM_SRC(NS)) bus ();

  interrupt_scheduler #(.NUM_SRC(NS), .VEC_BASE(VB)) dut (
    .trn_clk            (trn_clk),
    .reset              (reset),
    .interrupts_enabled (interrupts_enabled),
    .interrupt_period   (interrupt_period),
    .bus                (bus),
    .irq_count          (irq_count)
  );

  always #5 trn_clk = ~trn_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected delivered source indices, in order.
  int unsigned sb[$];
  logic [31:0] exp_count = '0;

  // Endpoint responder: accepts after rdy_dly cycles, or ties rdy_n low.
  int unsigned rdy_dly = 0;
  bit          rdy_tie = 1'b0;
  int unsigned wcnt = 0;

  always @(negedge trn_clk) begin
    if (rdy_tie) begin
      bus.cfg_interrupt_rdy_n = 1'b0;
    end else if (bus.cfg_interrupt_n == 1'b0) begin
      bus.cfg_interrupt_rdy_n = (wcnt == rdy_dly) ? 1'b0 : 1'b1;
      wcnt++;
    end else begin
      bus.cfg_interrupt_rdy_n = 1'b1;
      wcnt = 0;
    end
  end

  // Output monitor.
  int unsigned cyc = 0;
  int unsigned hs_cyc = 0;
  int unsigned hs_per = 0;
  int unsigned last_gap = 0;
  bit          have_hs = 1'b0;
  logic        prev_cfg = 1'b1;
  logic [7:0]  prev_di = '0;

  always @(negedge trn_clk) begin
    int unsigned e;
    int unsigned min_gap;
    cyc++;
    if (reset) begin
      have_hs  = 1'b0;
      prev_cfg = 1'b1;
    end else begin
      if (bus.src_ack != '0) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'(bus.src_ack), 32'd0);
        end else begin
          e = sb.pop_front();
          exp_count = exp_count + 32'd1;
          chk("ack_onehot", 32'(bus.src_ack), 32'd1 << e);
          chk("ack_vector", 32'(bus.cfg_interrupt_di), 32'(VB) + e);
          chk("irq_count", irq_count, exp_count);
          chk("cfg_n_release", 32'(bus.cfg_interrupt_n), 32'd1);
        end
        have_hs = 1'b1;
        hs_cyc  = cyc;
        hs_per  = interrupt_period;
      end
      if (prev_cfg && !bus.cfg_interrupt_n && have_hs) begin
        last_gap = cyc - hs_cyc;
        min_gap  = (hs_per > 2) ? hs_per : 2;
        chk("spacing_ok", 32'(last_gap >= min_gap), 32'd1);
      end
      if (!prev_cfg && !bus.cfg_interrupt_n)
        chk("di_stable", 32'(bus.cfg_interrupt_di), 32'(prev_di));
      prev_cfg = bus.cfg_interrupt_n;
      prev_di  = bus.cfg_interrupt_di;
    end
  end

  task automatic drain(input int unsigned extra);
    int unsigned t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge trn_clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (extra) @(negedge trn_clk);
  endtask

  task automatic wait_req();
    int unsigned t = 0;
    while (bus.cfg_interrupt_n !== 1'b0 && t < 50) begin
      @(negedge trn_clk);
      t++;
    end
    if (bus.cfg_interrupt_n !== 1'b0) chk("wait_req_timeout", 32'(bus.cfg_interrupt_n), 32'd0);
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    @(negedge trn_clk);
    bus.src_req = m;
    @(negedge trn_clk);
    bus.src_req = '0;
  endtask

  typedef struct {
    logic [NS-1:0] req;
    int unsigned   period;
    int unsigned   dly;
    int unsigned   exp0;
    int unsigned   exp1;
    int unsigned   n_exp;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    bit saw;
    // Round-robin order follows last grant, starting at source 1 after reset.
    vecs[0] = '{2'b01, 10, 3, 0, 0, 1};
    vecs[1] = '{2'b11, 10, 0, 1, 0, 2};
    vecs[2] = '{2'b10,  4, 1, 1, 0, 1};
    vecs[3] = '{2'b01,  1, 2, 0, 0, 1};
    vecs[4] = '{2'b11,  0, 0, 1, 0, 2};
    vecs[5] = '{2'b10,  3, 5, 1, 0, 1};
    vecs[6] = '{2'b11,  2, 0, 0, 1, 2};

    bus.src_req = '0;
    repeat (3) @(negedge trn_clk);
    reset = 1'b0;
    chk("rst_cfg_n", 32'(bus.cfg_interrupt_n), 32'd1);
    chk("rst_di", 32'(bus.cfg_interrupt_di), 32'd0);
    chk("rst_ack", 32'(bus.src_ack), 32'd0);
    chk("rst_count", irq_count, 32'd0);

    // Table: one burst per vector from idle; exact 2-edge request latency.
    foreach (vecs[k]) begin
      interrupt_period = vecs[k].period;
      rdy_dly = vecs[k].dly;
      @(negedge trn_clk);
      bus.src_req = vecs[k].req;
      sb.push_back(vecs[k].exp0);
      if (vecs[k].n_exp == 2) sb.push_back(vecs[k].exp1);
      @(negedge trn_clk);
      bus.src_req = '0;
      chk("lat_pending", 32'(bus.cfg_interrupt_n), 32'd1);
      @(negedge trn_clk);
      chk("lat_req", 32'(bus.cfg_interrupt_n), 32'd0);
      chk("lat_vec", 32'(bus.cfg_interrupt_di), 32'(VB) + vecs[k].exp0);
      drain(vecs[k].period + 4);
    end

    // Coalescing: five source-1 events during hold-off give one interrupt.
    interrupt_period = 20;
    rdy_dly = 0;
    sb.push_back(0);
    pulse(2'b01);
    drain(1);
    sb.push_back(1);
    repeat (5) pulse(2'b10);
    drain(24);

    // Disabled: pending accumulates, issued one edge after re-enable.
    interrupt_period = 3;
    interrupts_enabled = 1'b0;
    pulse(2'b01);
    saw = 1'b0;
    repeat (100) begin
      @(negedge trn_clk);
      if (!bus.cfg_interrupt_n) saw = 1'b1;
    end
    chk("disabled_no_req", 32'(saw), 32'd0);
    sb.push_back(0);
    interrupts_enabled = 1'b1;
    @(negedge trn_clk);
    chk("enable_latency", 32'(bus.cfg_interrupt_n), 32'd0);
    drain(7);

    // Disable while REQ is outstanding: request is not retracted.
    interrupt_period = 5;
    rdy_dly = 20;
    sb.push_back(1);
    pulse(2'b10);
    wait_req();
    interrupts_enabled = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(negedge trn_clk);
      if (bus.cfg_interrupt_n) saw = 1'b1;
    end
    chk("req_held_when_disabled", 32'(saw), 32'd0);
    drain(9);
    interrupts_enabled = 1'b1;

    // rdy_n low with no request is ignored; period 0 gives 2-cycle spacing.
    rdy_tie = 1'b1;
    interrupt_period = 0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge trn_clk);
      if (bus.src_ack != '0 || !bus.cfg_interrupt_n) saw = 1'b1;
    end
    chk("rdy_ignored", 32'(saw), 32'd0);
    sb.push_back(0);
    sb.push_back(1);
    pulse(2'b11);
    drain(6);
    chk("period0_gap", last_gap, 32'd2);
    rdy_tie = 1'b0;

    // Counter wrap.
    rdy_dly = 0;
    interrupt_period = 2;
    @(negedge trn_clk);
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    exp_count = 32'hFFFF_FFFE;
    @(negedge trn_clk);
    chk("preload", irq_count, 32'hFFFF_FFFE);
    sb.push_back(0);
    sb.push_back(1);
    pulse(2'b11);
    drain(6);
    chk("wrapped_count", irq_count, 32'd0);

    // Reset during REQ withdraws the request and discards pending events.
    interrupt_period = 3;
    rdy_dly = 30;
    sb.push_back(0);
    sb.push_back(1);
    pulse(2'b11);
    wait_req();
    reset = 1'b1;
    @(negedge trn_clk);
    chk("rst_req_cfg_n", 32'(bus.cfg_interrupt_n), 32'd1);
    chk("rst_req_count", irq_count, 32'd0);
    chk("rst_req_ack", 32'(bus.src_ack), 32'd0);
    chk("rst_req_di", 32'(bus.cfg_interrupt_di), 32'd0);
    sb.delete();
    exp_count = '0;
    @(negedge trn_clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      @(negedge trn_clk);
      if (!bus.cfg_interrupt_n || bus.src_ack != '0) saw = 1'b1;
    end
    chk("rst_discard_pending", 32'(saw), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
